// File: rtl/ov_init_sequencer.sv
// Purpose: walks a per-bank table of WRITE/DELAY/END entries from a 1-cycle
//          synchronous ROM and issues each WRITE as a sub_addr/data word to an
//          SCCB master over a valid/ready stream.
// Latency: start to first m_valid is 3 cycles; one word every 3 cycles with
//          m_ready held high.
// Backpressure: SEND holds sub_addr/data and m_valid until m_ready; the table
//          walk stalls meanwhile.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, bank_sel    run request and bank, sampled only in IDLE/DONE
//   abort              return to IDLE immediately, highest priority
//   tbl_bank, tbl_idx  ROM address; tbl_entry is ROM data one cycle later
//   m_valid, m_ready   write-word handshake carrying sub_addr/data
//   busy, done         status levels; done_pulse marks the rising edge of done
//   err                one-cycle pulse when a start names a nonexistent bank
module ov_init_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NUM_ENTRIES = 256,
  parameter int NUM_BANKS   = 2,
  parameter int DELAY_UNIT  = 1000,
  parameter int AUTO_START  = 1,
  localparam int IDX_W  = $clog2(NUM_ENTRIES),
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int ENT_W  = 2 + ADDR_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic              abort,
  output logic [BANK_W-1:0] tbl_bank,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [ENT_W-1:0]  tbl_entry,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] sub_addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              done_pulse,
  output logic              err
);

  localparam int PRE_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_DELAY, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [BANK_W-1:0]   r_bank;
  logic [IDX_W-1:0]    r_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_ticks;
  logic [PRE_W-1:0]    r_pre;
  logic                r_done, r_done_pulse, r_err;
  // Set by reset when AUTO_START: makes the first clock behave as a start of bank 0.
  logic                r_auto;

  logic [1:0]          w_op;
  logic [ADDR_W-1:0]   w_ent_addr;
  logic [DATA_W-1:0]   w_ent_data;
  logic                w_can_start, w_bank_ok, w_accept, w_reject;
  logic [BANK_W-1:0]   w_start_bank;
  logic                w_last, w_pre_end, w_delay_end, w_entry_done, w_enter_done;

  assign w_op       = tbl_entry[ENT_W-1 -: 2];
  assign w_ent_addr = tbl_entry[DATA_W +: ADDR_W];
  assign w_ent_data = tbl_entry[DATA_W-1:0];

  assign w_can_start  = ((r_state == S_IDLE) || (r_state == S_DONE)) && !abort;
  assign w_bank_ok    = 32'(bank_sel) < NUM_BANKS;
  assign w_accept     = w_can_start && (r_auto || (start && w_bank_ok));
  assign w_reject     = w_can_start && !r_auto && start && !w_bank_ok;
  assign w_start_bank = r_auto ? '0 : bank_sel;

  assign w_last    = (r_idx == IDX_W'(NUM_ENTRIES - 1));
  assign w_pre_end = (r_pre == PRE_W'(DELAY_UNIT - 1));
  // A zero count leaves after one cycle; otherwise leave on the last prescaler
  // cycle of the last tick, giving exactly data*DELAY_UNIT cycles.
  assign w_delay_end = (r_ticks == '0) || ((r_ticks == DATA_W'(1)) && w_pre_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_entry_done = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_state_nxt = S_FETCH;
      S_FETCH:        w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (w_op)
          2'b00:   w_state_nxt = S_SEND;
          2'b01:   w_state_nxt = S_DELAY;
          2'b10:   w_state_nxt = S_DONE;
          default: w_entry_done = 1'b1;
        endcase
      end
      S_SEND:  if (m_ready)     w_entry_done = 1'b1;
      S_DELAY: if (w_delay_end) w_entry_done = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
    // The last table slot ends the run instead of wrapping the index.
    if (w_entry_done) w_state_nxt = w_last ? S_DONE : S_FETCH;
    if (abort)        w_state_nxt = S_IDLE;
  end

  assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank       <= '0;
      r_idx        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_ticks      <= '0;
      r_pre        <= '0;
      r_done       <= 1'b0;
      r_done_pulse <= 1'b0;
      r_err        <= 1'b0;
      r_auto       <= (AUTO_START != 0);
    end else begin
      r_auto       <= 1'b0;
      r_err        <= w_reject;
      r_done_pulse <= w_enter_done;

      if (w_accept) begin
        r_bank <= w_start_bank;
        r_idx  <= '0;
        r_done <= 1'b0;
      end else begin
        if (w_entry_done && !w_last && !abort) r_idx <= r_idx + 1'b1;
        if (w_enter_done)                      r_done <= 1'b1;
      end

      if (r_state == S_DECODE) begin
        if (w_op == 2'b00) begin
          r_addr <= w_ent_addr;
          r_data <= w_ent_data;
        end
        r_ticks <= w_ent_data;
        r_pre   <= '0;
      end else if (r_state == S_DELAY) begin
        if (w_pre_end) begin
          r_pre   <= '0;
          r_ticks <= r_ticks - 1'b1;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end
    end
  end

  assign tbl_bank   = r_bank;
  assign tbl_idx    = r_idx;
  assign m_valid    = (r_state == S_SEND);
  assign sub_addr   = r_addr;
  assign data       = r_data;
  assign busy       = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                      (r_state == S_SEND)  || (r_state == S_DELAY);
  assign done       = r_done;
  assign done_pulse = r_done_pulse;
  assign err        = r_err;

endmodule
